// File: rtl/register_writeback_pkg.sv
// Shared types for the integer register-file writeback path: request bundles, FIFO entries
// and the write/read port views of the register file.
package register_writeback_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } writeback_in_type;

  typedef struct packed {
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] pending;
    logic            empty;
    logic            s1_ready;
  } writeback_out_type;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } wb_fifo_entry_type;

  typedef struct packed {
    logic            wren;
    logic [RAW-1:0]  waddr;
    logic [XLEN-1:0] wdata;
  } register_write_in_type;

  typedef struct packed {
    logic           rden;
    logic [RAW-1:0] raddr;
  } register_read_in_type;

  function automatic logic [XLEN-1:0] reg_bit(input logic [RAW-1:0] addr);
    return XLEN'(1) << addr;
  endfunction

endpackage

// File: rtl/register_writeback_fifo.sv
// Circular buffer for long-latency writeback results, with kill-by-address and a
// youngest-valid-entry search used by the read-port forwarding.
module writeback_fifo
  import register_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  writeback_in_type         i_push,
  input  logic                     i_pop,
  input  logic                     i_kill_valid,
  input  logic [RAW-1:0]           i_kill_addr,
  input  logic [RAW-1:0]           i_match_addr1,
  input  logic [RAW-1:0]           i_match_addr2,
  output wb_fifo_entry_type        o_head,
  output wb_fifo_entry_type        o_entries [DEPTH],
  output logic                     o_full,
  output logic                     o_occupied,
  output logic                     o_hit1,
  output logic [$clog2(DEPTH)-1:0] o_hit_idx1,
  output logic                     o_hit2,
  output logic [$clog2(DEPTH)-1:0] o_hit_idx2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_fifo_entry_type r_entries [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_occupied = (r_count != '0);
  assign w_push     = i_push.valid && !o_full;
  assign w_pop      = i_pop && o_occupied;
  assign o_head     = r_entries[r_rd_ptr];
  assign o_entries  = r_entries;

  // The push assignment comes last so it overrides a kill that matched the stale slot contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_valid && r_entries[i].addr == i_kill_addr) r_entries[i].valid <= 1'b0;
      end
      if (w_pop) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_entries[r_wr_ptr] <= '{valid: !(i_kill_valid && i_kill_addr == i_push.addr),
                                 addr:  i_push.addr,
                                 data:  i_push.data};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Walk oldest to youngest so the final hit is the youngest valid entry.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx      = '0;
    o_hit1     = 1'b0;
    o_hit_idx1 = '0;
    o_hit2     = 1'b0;
    o_hit_idx2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + PW'(k);
      if (r_entries[v_idx].valid && r_entries[v_idx].addr == i_match_addr1) begin
        o_hit1     = 1'b1;
        o_hit_idx1 = v_idx;
      end
      if (r_entries[v_idx].valid && r_entries[v_idx].addr == i_match_addr2) begin
        o_hit2     = 1'b1;
        o_hit_idx2 = v_idx;
      end
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Register-file writer: merges commit-path and buffered long-latency results onto the single
// write port, and forwards in-flight values to both read ports.
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_s0_valid,
  input  logic [RAW-1:0]  i_s0_addr,
  input  logic [XLEN-1:0] i_s0_data,
  input  logic            i_s1_valid,
  output logic            o_s1_ready,
  input  logic [RAW-1:0]  i_s1_addr,
  input  logic [XLEN-1:0] i_s1_data,
  output logic            o_wren,
  output logic [RAW-1:0]  o_waddr,
  output logic [XLEN-1:0] o_wdata,
  input  logic            i_rden1,
  input  logic            i_rden2,
  input  logic [RAW-1:0]  i_raddr1,
  input  logic [RAW-1:0]  i_raddr2,
  input  logic [XLEN-1:0] i_rf_rdata1,
  input  logic [XLEN-1:0] i_rf_rdata2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2,
  output logic [XLEN-1:0] o_pending,
  output logic            o_empty
);

  localparam int PW = $clog2(DEPTH);

  writeback_in_type      w_s0;
  writeback_in_type      w_push;
  register_read_in_type  w_rd1;
  register_read_in_type  w_rd2;
  register_write_in_type r_wb;
  writeback_out_type     w_out;
  wb_fifo_entry_type     w_head;
  wb_fifo_entry_type     w_entries [DEPTH];
  logic                  w_full;
  logic                  w_occupied;
  logic                  w_pop;
  logic                  w_s1_ready;
  logic                  w_hit1;
  logic                  w_hit2;
  logic [PW-1:0]         w_hit_idx1;
  logic [PW-1:0]         w_hit_idx2;

  // Writes to x0 are accepted but never become live requests.
  assign w_s0       = '{valid: i_s0_valid && (i_s0_addr != '0), addr: i_s0_addr, data: i_s0_data};
  assign w_s1_ready = i_rst_n && !w_full;
  assign w_push     = '{valid: i_s1_valid && w_s1_ready && (i_s1_addr != '0),
                        addr:  i_s1_addr,
                        data:  i_s1_data};
  assign w_pop      = !w_s0.valid && w_occupied;
  assign w_rd1      = '{rden: i_rden1, raddr: i_raddr1};
  assign w_rd2      = '{rden: i_rden2, raddr: i_raddr2};

  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_kill_valid  (w_s0.valid),
    .i_kill_addr   (w_s0.addr),
    .i_match_addr1 (i_raddr1),
    .i_match_addr2 (i_raddr2),
    .o_head        (w_head),
    .o_entries     (w_entries),
    .o_full        (w_full),
    .o_occupied    (w_occupied),
    .o_hit1        (w_hit1),
    .o_hit_idx1    (w_hit_idx1),
    .o_hit2        (w_hit2),
    .o_hit_idx2    (w_hit_idx2)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb <= '0;
    end else if (w_s0.valid) begin
      r_wb <= '{wren: 1'b1, waddr: w_s0.addr, wdata: w_s0.data};
    end else if (w_pop && w_head.valid) begin
      r_wb <= '{wren: 1'b1, waddr: w_head.addr, wdata: w_head.data};
    end else begin
      r_wb <= '0;
    end
  end

  function automatic logic [XLEN-1:0] forward(input register_read_in_type  rd,
                                              input writeback_in_type      s0,
                                              input logic                  hit,
                                              input logic [XLEN-1:0]       hit_data,
                                              input register_write_in_type wb,
                                              input logic [XLEN-1:0]       rf_data);
    logic [XLEN-1:0] v_res;
    if (!rd.rden || rd.raddr == '0)              v_res = '0;
    else if (s0.valid && s0.addr == rd.raddr)    v_res = s0.data;
    else if (hit)                                v_res = hit_data;
    else if (wb.wren && wb.waddr == rd.raddr)    v_res = wb.wdata;
    else                                         v_res = rf_data;
    return v_res;
  endfunction

  always_comb begin
    w_out          = '0;
    w_out.s1_ready = w_s1_ready;
    w_out.empty    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entries[i].valid) begin
        w_out.pending = w_out.pending | reg_bit(w_entries[i].addr);
        w_out.empty   = 1'b0;
      end
    end
    w_out.pending[0] = 1'b0;
    w_out.rdata1 = forward(w_rd1, w_s0, w_hit1, w_entries[w_hit_idx1].data, r_wb, i_rf_rdata1);
    w_out.rdata2 = forward(w_rd2, w_s0, w_hit2, w_entries[w_hit_idx2].data, r_wb, i_rf_rdata2);
  end

  assign o_s1_ready = w_out.s1_ready;
  assign o_wren     = r_wb.wren;
  assign o_waddr    = r_wb.waddr;
  assign o_wdata    = r_wb.wdata;
  assign o_rdata1   = w_out.rdata1;
  assign o_rdata2   = w_out.rdata2;
  assign o_pending  = w_out.pending;
  assign o_empty    = w_out.empty;

endmodule
